ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter. It sends command bytes to the keyboard, for example 0xED for set-LEDs, 0xF4 for enable and 0xFF for reset. It sits beside kbd_ctrl on the same ps2_clk/ps2_data pair and drives the lines as open-drain via output enables. It performs clock inhibit, request-to-send, a bit-serial frame with odd parity and stop bit, and device ACK check. It reports completion or error to the command source.

---
 rtl/ps2_host_tx.sv | 182 ++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, 11-bit frame, device ACK.
// Lines are open-drain; an asserted *_oe pulls the line low.
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk_i,
   input  logic       ps2_data_i,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   input  logic       tx_valid,
   input  logic [7:0] tx_data,
   output logic       tx_ready,
   output logic       busy,
   output logic       done,
   output logic       error
);

   localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
   localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT_CYCLES);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_INHIBIT   = 3'd1,
      S_RTS       = 3'd2,
      S_SHIFT     = 3'd3,
      S_ACK       = 3'd4,
      S_WAIT_IDLE = 3'd5
   } state_t;

   function automatic logic odd_parity(input logic [7:0] d);
      return ~^d;
   endfunction

   state_t          state_r;
   state_t          state_nxt_s;
   logic [1:0]      clk_sync_r;
   logic [1:0]      data_sync_r;
   logic            clk_prev_r;
   logic            clk_s;
   logic            data_s;
   logic            fall_s;
   logic            accept_s;
   logic            timeout_s;
   logic [CW-1:0]   cnt_r;
   logic [3:0]      bitcnt_r;
   logic [8:0]      frame_r;
   logic            data_oe_r;

   assign clk_s     = clk_sync_r[1];
   assign data_s    = data_sync_r[1];
   assign fall_s    = clk_prev_r & ~clk_s;
   assign accept_s  = tx_valid & (state_r == S_IDLE);
   assign timeout_s = (cnt_r == TO_LIMIT);

   // Two-flop synchronisers; reset to the idle-high line level so reset never fakes a fall
   always_ff @(posedge clk) begin
      if (rst) begin
         clk_sync_r  <= 2'b11;
         data_sync_r <= 2'b11;
         clk_prev_r  <= 1'b1;
      end else begin
         clk_sync_r  <= {clk_sync_r[0], ps2_clk_i};
         data_sync_r <= {data_sync_r[0], ps2_data_i};
         clk_prev_r  <= clk_sync_r[1];
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic; timeout wins over any line event in the same cycle
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         S_IDLE:      if (accept_s) state_nxt_s = S_INHIBIT; else state_nxt_s = S_IDLE;
         S_INHIBIT:   if (cnt_r == INH_LAST) state_nxt_s = S_RTS; else state_nxt_s = S_INHIBIT;
         S_RTS:       if (timeout_s) state_nxt_s = S_IDLE; else state_nxt_s = S_SHIFT;
         S_SHIFT: begin
            if (timeout_s)                             state_nxt_s = S_IDLE;
            else if (fall_s && (bitcnt_r == 4'd9))     state_nxt_s = S_ACK;
            else                                       state_nxt_s = S_SHIFT;
         end
         S_ACK: begin
            if (timeout_s)   state_nxt_s = S_IDLE;
            else if (fall_s) state_nxt_s = data_s ? S_IDLE : S_WAIT_IDLE;
            else             state_nxt_s = S_ACK;
         end
         S_WAIT_IDLE: begin
            if (timeout_s)             state_nxt_s = S_IDLE;
            else if (clk_s && data_s)  state_nxt_s = S_IDLE;
            else                       state_nxt_s = S_WAIT_IDLE;
         end
         default:     state_nxt_s = S_IDLE;
      endcase
   end

   // Output decode from registered state; done/error fire in the last cycle before IDLE
   always_comb begin
      ps2_clk_oe  = 1'b0;
      ps2_data_oe = 1'b0;
      done        = 1'b0;
      error       = 1'b0;
      tx_ready    = (state_r == S_IDLE);
      busy        = (state_r != S_IDLE);
      case (state_r)
         S_INHIBIT: begin
            ps2_clk_oe  = 1'b1;
            ps2_data_oe = (cnt_r == INH_LAST);
         end
         S_RTS: begin
            ps2_data_oe = 1'b1;
            error       = timeout_s;
         end
         S_SHIFT: begin
            ps2_data_oe = data_oe_r;
            error       = timeout_s;
         end
         S_ACK: begin
            error = timeout_s | (fall_s & data_s);
         end
         S_WAIT_IDLE: begin
            error = timeout_s;
            done  = ~timeout_s & clk_s & data_s;
         end
         default: begin
            ps2_clk_oe = 1'b0;
         end
      endcase
   end

   // Shared counter: inhibit length, then cycles since RTS entry for the timeout
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r <= '0;
      end else begin
         case (state_r)
            S_INHIBIT:   cnt_r <= (cnt_r == INH_LAST) ? '0 : cnt_r + CW'(1);
            S_RTS,
            S_SHIFT,
            S_ACK,
            S_WAIT_IDLE: cnt_r <= cnt_r + CW'(1);
            default:     cnt_r <= '0;
         endcase
      end
   end

   // Frame shifter: ones shift in behind the parity bit, so the tenth fall releases data (stop)
   always_ff @(posedge clk) begin
      if (rst) begin
         frame_r   <= 9'h000;
         bitcnt_r  <= 4'd0;
         data_oe_r <= 1'b0;
      end else if (accept_s) begin
         frame_r   <= {odd_parity(tx_data), tx_data};
         bitcnt_r  <= 4'd0;
         data_oe_r <= 1'b0;
      end else if (state_r == S_RTS) begin
         bitcnt_r  <= 4'd0;
         data_oe_r <= 1'b1;
      end else if ((state_r == S_SHIFT) && fall_s) begin
         data_oe_r <= ~frame_r[0];
         frame_r   <= {1'b1, frame_r[8:1]};
         bitcnt_r  <= bitcnt_r + 4'd1;
      end else if (state_r == S_SHIFT) begin
         data_oe_r <= data_oe_r;
      end else begin
         data_oe_r <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain device model clocking at 40 cycles/period.
module tb_ps2_host_tx;

   logic       clk = 1'b0;
   logic       rst;
   logic       ps2_clk_oe;
   logic       ps2_data_oe;
   logic       tx_valid;
   logic [7:0] tx_data;
   logic       tx_ready;
   logic       busy;
   logic       done;
   logic       error;
   logic       dev_clk_low;
   logic       dev_data_low;
   logic       line_clk;
   logic       line_data;

   int checks   = 0;
   int failures = 0;
   int done_cnt = 0;
   int err_cnt  = 0;

   assign line_clk  = ~(ps2_clk_oe | dev_clk_low);
   assign line_data = ~(ps2_data_oe | dev_data_low);

   always #5 clk = ~clk;

   ps2_host_tx #(.INHIBIT_CYCLES(20), .TIMEOUT_CYCLES(4000)) dut (
      .clk(clk), .rst(rst),
      .ps2_clk_i(line_clk), .ps2_data_i(line_data),
      .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe),
      .tx_valid(tx_valid), .tx_data(tx_data),
      .tx_ready(tx_ready), .busy(busy), .done(done), .error(error)
   );

   // Pulse counters for done/error
   always @(posedge clk) begin
      if (done)  done_cnt <= done_cnt + 1;
      if (error) err_cnt  <= err_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Offer one byte, then count the inhibit cycles; returns in the RTS cycle
   task automatic host_send(input logic [7:0] b, output int inh);
      @(negedge clk);
      tx_valid = 1'b1;
      tx_data  = b;
      @(negedge clk);
      tx_valid = 1'b0;
      inh = 0;
      while (ps2_clk_oe && inh < 1000) begin
         inh++;
         @(negedge clk);
      end
   endtask

   // Device generates nf falls, sampling the data line in each low phase
   task automatic dev_clocks(input int nf, output logic [9:0] seen);
      seen = 10'h000;
      for (int k = 0; k < nf; k++) begin
         repeat (20) @(negedge clk);
         dev_clk_low = 1'b1;
         repeat (20) @(negedge clk);
         seen[k] = line_data;
         dev_clk_low = 1'b0;
      end
      repeat (20) @(negedge clk);
   endtask

   // Eleventh fall with the device pulling data low, then idle the bus
   task automatic dev_ack();
      dev_data_low = 1'b1;
      repeat (5) @(negedge clk);
      dev_clk_low = 1'b1;
      repeat (20) @(negedge clk);
      dev_clk_low = 1'b0;
      repeat (5) @(negedge clk);
      dev_data_low = 1'b0;
      repeat (10) @(negedge clk);
   endtask

   task automatic full_xfer(input string tag, input logic [7:0] b, input logic par);
      int inh;
      int d0;
      int e0;
      logic [9:0] seen;
      d0 = done_cnt;
      e0 = err_cnt;
      host_send(b, inh);
      chk({tag, "_inhibit"}, 32'(inh), 32'd20);
      chk({tag, "_rts_data_oe"}, 32'(ps2_data_oe), 32'd1);
      dev_clocks(10, seen);
      chk({tag, "_bits"}, 32'(seen[7:0]), 32'(b));
      chk({tag, "_parity"}, 32'(seen[8]), 32'(par));
      chk({tag, "_stop"}, 32'(seen[9]), 32'd1);
      dev_ack();
      chk({tag, "_done"}, 32'(done_cnt - d0), 32'd1);
      chk({tag, "_no_error"}, 32'(err_cnt - e0), 32'd0);
      chk({tag, "_ready"}, 32'(tx_ready), 32'd1);
   endtask

   initial begin
      int inh;
      int n;
      int d0;
      int e0;
      logic [9:0] seen;
      rst = 1'b1;
      tx_valid = 1'b0;
      tx_data = 8'h00;
      dev_clk_low = 1'b0;
      dev_data_low = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_ready", 32'(tx_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
      chk("rst_pulses", 32'({done, error}), 32'd0);

      full_xfer("ed", 8'hED, 1'b1);
      full_xfer("f4", 8'hF4, 1'b0);
      full_xfer("00", 8'h00, 1'b1);
      full_xfer("ff", 8'hFF, 1'b1);

      // Missing ACK: data stays high at the eleventh fall
      d0 = done_cnt;
      e0 = err_cnt;
      host_send(8'hF4, inh);
      dev_clocks(10, seen);
      dev_clk_low = 1'b1;
      n = 0;
      while (!error && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("nack_error_seen", 32'(error), 32'd1);
      @(negedge clk);
      chk("nack_oe_released", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
      chk("nack_ready", 32'(tx_ready), 32'd1);
      chk("nack_no_done", 32'(done_cnt - d0), 32'd0);
      chk("nack_one_error", 32'(err_cnt - e0), 32'd1);
      dev_clk_low = 1'b0;
      repeat (20) @(negedge clk);

      // Device never clocks: error exactly 4000 cycles after RTS entry
      d0 = done_cnt;
      host_send(8'hF4, inh);
      n = 0;
      while (!error && n < 5000) begin
         @(negedge clk);
         n++;
      end
      chk("timeout_cycles", 32'(n), 32'd4000);
      @(negedge clk);
      chk("timeout_oe_released", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
      chk("timeout_ready", 32'(tx_ready), 32'd1);
      chk("timeout_no_done", 32'(done_cnt - d0), 32'd0);

      // Reset in the middle of SHIFT after four falls
      host_send(8'hA5, inh);
      dev_clocks(4, seen);
      chk("pre_rst_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_rst_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_ready", 32'(tx_ready), 32'd1);
      repeat (5) @(negedge clk);
      full_xfer("post_rst_ff", 8'hFF, 1'b1);

      // 0x55 offered while busy must be dropped
      d0 = done_cnt;
      host_send(8'hED, inh);
      tx_valid = 1'b1;
      tx_data  = 8'h55;
      @(negedge clk);
      tx_valid = 1'b0;
      dev_clocks(10, seen);
      chk("busy_bits", 32'(seen[7:0]), 32'h0000_00ED);
      dev_ack();
      chk("busy_done", 32'(done_cnt - d0), 32'd1);
      repeat (30) @(negedge clk);
      chk("busy_no_requeue", 32'({ps2_clk_oe, busy}), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
